// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with a selectable wrap-around or one-shot stop at the terminal value.
// Clear and load are synchronous. tc is combinational so that counters can be cascaded through en.
module updown_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  // state | meaning
  // RUN   | counting, or holding while en=0
  // DONE  | one-shot reached its terminal value; q is frozen until clr or load
  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_start;
  logic             w_at_term;

  assign w_term    = up ? MAX : '0;
  assign w_start   = up ? '0 : MAX;
  assign w_at_term = (r_q == w_term);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_RUN;
      r_q     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_wrap_nxt  = 1'b0;
    if (clr) begin
      w_q_nxt     = w_start;
      w_state_nxt = S_RUN;
    end else if (load) begin
      // Out-of-range load values clamp to the top of the count range.
      w_q_nxt     = ({1'b0, load_val} >= MOD_W) ? MAX : load_val;
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN && en) begin
      if (w_at_term) begin
        if (!mode) begin
          w_q_nxt    = w_start;
          w_wrap_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end else begin
        w_q_nxt = up ? (r_q + ONE) : (r_q - ONE);
      end
    end
  end

  assign q    = r_q;
  assign tc   = w_at_term && en;
  assign wrap = r_wrap;
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: the main instance is checked against a small behavioural model through a scoreboard,
// with a two-stage decade cascade and a WIDTH=3 instance alongside it.
module tb_updown_mod_counter;
  localparam int MOD = 10;

  typedef struct {
    int q;
    int wrap;
    int done;
    int tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 0, up = 1, mode = 0, clr = 0, load = 0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic       tc, wrap, done;

  logic       c_en = 0, c_clr = 0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_done, hi_done;

  logic       e8 = 0, c8 = 0;
  logic [2:0] q8;
  logic       tc8, wrap8, done8;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   cq[$];
  int   m_q = 0, m_wrap = 0, m_done = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .mode(mode), .clr(clr), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .done(done));

  updown_mod_counter #(.WIDTH(4), .MOD(10)) u_lo (
    .clk(clk), .rstn(rstn), .en(c_en), .up(1'b1), .mode(1'b0), .clr(c_clr), .load(1'b0),
    .load_val(4'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .done(lo_done));

  updown_mod_counter #(.WIDTH(4), .MOD(10)) u_hi (
    .clk(clk), .rstn(rstn), .en(lo_tc), .up(1'b1), .mode(1'b0), .clr(c_clr), .load(1'b0),
    .load_val(4'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .done(hi_done));

  updown_mod_counter #(.WIDTH(3), .MOD(8)) u_w3 (
    .clk(clk), .rstn(rstn), .en(e8), .up(1'b1), .mode(1'b0), .clr(c8), .load(1'b0),
    .load_val(3'd0), .q(q8), .tc(tc8), .wrap(wrap8), .done(done8));

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock edge of the reference behaviour, evaluated on the currently driven inputs.
  task automatic m_edge();
    int t;
    t = up ? MOD - 1 : 0;
    m_wrap = 0;
    if (clr) begin
      m_q = up ? 0 : MOD - 1;
      m_done = 0;
    end else if (load) begin
      m_q = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      m_done = 0;
    end else if (m_done == 0 && en) begin
      if (m_q == t) begin
        if (!mode) begin
          m_q = up ? 0 : MOD - 1;
          m_wrap = 1;
        end else begin
          m_done = 1;
        end
      end else begin
        m_q = up ? m_q + 1 : m_q - 1;
      end
    end
  endtask

  task automatic step(input string tag);
    exp_t e, g;
    m_edge();
    e.q = m_q;
    e.wrap = m_wrap;
    e.done = m_done;
    e.tc = (m_q == (up ? MOD - 1 : 0)) && en;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({tag, ".q"}, int'(q), g.q);
    chk({tag, ".wrap"}, int'(wrap), g.wrap);
    chk({tag, ".done"}, int'(done), g.done);
    chk({tag, ".tc"}, int'(tc), g.tc);
  endtask

  task automatic idle_inputs();
    en = 0; clr = 0; load = 0; mode = 0; up = 1; load_val = '0;
  endtask

  initial begin
    int c;
    #12;
    chk("rst.q", int'(q), 0);
    chk("rst.wrap", int'(wrap), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.tc", int'(tc), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset applied mid-count takes effect without a clock edge.
    en = 1; up = 1;
    for (int i = 0; i < 6; i++) step("cnt6");
    chk("pre_rst.q", int'(q), 6);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst.q", int'(q), 0);
    chk("async_rst.wrap", int'(wrap), 0);
    chk("async_rst.done", int'(done), 0);
    m_q = 0; m_wrap = 0; m_done = 0;
    #1 rstn = 1'b1;
    for (int i = 0; i < 2; i++) step("resume");

    // Up wrap from 0.
    idle_inputs(); clr = 1;
    step("clr_up");
    clr = 0; en = 1;
    for (int i = 0; i < 12; i++) step("up_wrap");

    // Clamped load, then count down through the wrap.
    idle_inputs(); load = 1; load_val = 4'd13;
    step("load_clamp");
    chk("load_clamp.val", int'(q), 9);
    load = 0; up = 0; en = 1;
    for (int i = 0; i < 10; i++) step("down_wrap");
    chk("down_wrap.end", int'(q), 9);

    // One-shot stop and DONE hold.
    idle_inputs(); mode = 1; load = 1; load_val = 4'd7; en = 1;
    step("os_load");
    load = 0;
    for (int i = 0; i < 4; i++) step("os_run");
    chk("os.done", int'(done), 1);
    en = 0; step("os_en0");
    en = 1; up = 0; step("os_down");
    up = 1; step("os_up");
    chk("os.hold", int'(q), 9);
    up = 0; clr = 1; en = 0;
    step("os_clr");
    chk("os_clr.q", int'(q), 9);
    chk("os_clr.done", int'(done), 0);

    // Priority: clr over load over step, then load over step.
    idle_inputs(); clr = 1; load = 1; load_val = 4'd4; en = 1; up = 1;
    step("prio_clr");
    clr = 0;
    step("prio_load");
    chk("prio_load.val", int'(q), 4);
    idle_inputs();

    // Two-stage decade cascade across the full 00..99 range.
    c_clr = 1;
    @(posedge clk); #1;
    c_clr = 0; c_en = 1;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      c = (c + 1) % 100;
      cq.push_back(c);
      @(posedge clk); #1;
      chk("cascade", int'(hi_q) * 10 + int'(lo_q), cq.pop_front());
      if (i == 98) chk("cascade.99", int'(hi_q) * 10 + int'(lo_q), 99);
    end
    chk("cascade.00", int'(hi_q) * 10 + int'(lo_q), 0);
    chk("cascade.hi_wrap", int'(hi_wrap), 1);
    c_en = 0;

    // Power-of-two modulus relies on natural overflow.
    c8 = 1;
    @(posedge clk); #1;
    c8 = 0; e8 = 1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("w3.q", int'(q8), (i + 1) % 8);
      chk("w3.wrap", int'(wrap8), (i == 7) ? 1 : 0);
    end
    e8 = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down modulo counter, the successor to the fixed 3-bit toggle counter used in the lab designs. It adds selectable width and modulus, a runtime direction, synchronous clear and parallel load, and a choice of wrap-around or one-shot stop at the terminal value. It drives digit/timebase logic, such as display multiplexing, BCD digit chains and delay timers, and cascades through `tc` into `en`.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..16.
- `MOD`, default 16: count range 0..MOD-1; legal range 2..2^WIDTH.
- `clk`  input  1  rising-edge clock; the only clock.
- `rstn`  input  1  asynchronous, active-low reset.
- `en`  input  1  count enable; one step per cycle while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement.
- `mode`  input  1  0 = wrap-around, 1 = one-shot (stop at terminal).
- `clr`  input  1  synchronous clear to the start value.
- `load`  input  1  synchronous parallel load.
- `load_val`  input  WIDTH  value taken on `load`.
- `q`  output  WIDTH  current count.
- `tc`  output  1  combinational terminal-count flag.
- `wrap`  output  1  registered one-cycle wrap pulse.
- `done`  output  1  registered flag; high in one-shot DONE state.

## Operation
- Start value: 0 when `up`=1, MOD-1 when `up`=0. Both are sampled in the cycle `clr` is applied.
- Terminal value T: MOD-1 when `up`=1, 0 when `up`=0.
- `tc` = (`q` == T) && `en`. It is purely combinational and is used to cascade the next stage.
- Per-edge priority: `clr` > `load` > count step > hold.
- `clr`: `q` takes the start value, the FSM goes to RUN, and `done` and `wrap` go to 0.
- `load`: `q` takes `load_val`. If `load_val` >= MOD, `q` takes MOD-1 (clamped). The FSM goes to RUN and `done` goes to 0.
- FSM has two states:
  - RUN (reset state).
  - DONE.
- RUN with `en`=1 and `q` != T: `q` steps by +1 or -1 according to `up`.
- RUN with `en`=1 and `q` == T, `mode`=0:
  - `q` wraps: 0 when counting up, MOD-1 when counting down.
  - `wrap` is 1 for exactly the next cycle.
- RUN with `en`=1 and `q` == T, `mode`=1:
  - `q` holds at T.
  - The FSM enters DONE and `done` goes to 1.
  - `wrap` stays 0.
- DONE:
  - `q` holds regardless of `en`, `up` and `mode`.
  - Only `clr` or `load` leaves DONE.
  - `tc` still follows its equation.
- `en`=0 in RUN: `q` holds and `wrap` is 0.
- A change of `up` or `mode` takes effect on the next edge. No pipeline flush is needed.
- Arithmetic is done modulo MOD at WIDTH bits, so no intermediate value ever reaches MOD. With MOD = 2^WIDTH the natural overflow gives the same result.

## Timing
- Reset (`rstn`=0, asynchronous): `q`=0, FSM=RUN, `wrap`=0, `done`=0.
- Deassertion of `rstn` is synchronised by the integrator. The first edge after release may already count.
- Latency from `en`, `clr` or `load` to `q`: 1 cycle. `q` changes only on rising `clk`.
- `wrap` and `done` are registered. They assert on the same edge that `q` takes its wrapped or held value.
- `tc` has zero latency relative to `q`, `up` and `en`.
- When `clr` and `load` are asserted together, `clr` wins.
- `load` with `en`=1 in the same cycle: the load wins and no step occurs.
- `rstn` asserted mid-count or in DONE: all outputs go to their reset values immediately, without waiting for a clock edge.
- A cascade of N stages advances the upper stage on the edge where the lower stage's `tc`=1.

## Test plan
Run with WIDTH=4, MOD=10 unless stated.
1. Reset mid-count: count to 6, then pulse `rstn` low between edges -> `q`=0, `wrap`=0 and `done`=0 immediately; after release counting resumes 1, 2, ...
2. Up wrap: `up`=1, `mode`=0, `en`=1 for 12 cycles from 0 -> `q` = 1..9, 0, 1, 2. `tc`=1 only while `q`=9. `wrap`=1 only in the cycle `q`=0 after 9.
3. Down wrap with clamped load: `load_val`=13 with `load`=1 -> `q`=9. Then `up`=0, `en`=1 -> `q` = 8..0, 9. `wrap` pulses with `q`=9. `tc`=1 at `q`=0.
4. One-shot: `mode`=1, `up`=1, `load_val`=7 loaded, `en`=1 -> `q` = 8, 9, 9, 9. `done`=1 from the edge that keeps `q` at 9 and `wrap` stays 0. Toggling `en` or `up` leaves `q`=9. `clr` with `up`=0 -> `q`=9, `done`=0, FSM in RUN.
5. Priority: `clr`, `load` (`load_val`=4) and `en` all at 1 on one edge -> `q`=start value. Next edge with `load`+`en` -> `q`=4, not 5.
6. Cascade and full range: two instances with MOD=10, the upper stage's `en` = the lower stage's `tc`, 100 edges from 00 -> the pair reads 99 then 00. Repeat with WIDTH=3, MOD=8: `q` wraps 7 -> 0 with `wrap`=1.
